sprite_rom_arbiter: RTL and testbench
=====================================

# sprite_rom_arbiter

- Shares the single-port, 1-bit-wide sprite BRAM among `N_REQ` sprite renderers.
- Sits between the sprite instances in `main_display` and the sprite BRAM port, replacing the address-summing hookup.
- Grants one requester per `clk_65mhz` cycle, drives the BRAM address, and returns the read bit to the granted requester after a fixed latency.
- Each returned bit carries a per-requester valid strobe.

## Interface
- `N_REQ`, default 3: number of requesters, 2..8.
- `ADR_W`, default 16: sprite BRAM address width.
- `RD_LAT`, default 1: BRAM read latency in cycles, from address registered to data valid; range 1..4.
- `clk_65mhz`  input  1  pixel clock; all logic on its rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `fetch_en`  input  1  grants are allowed only while high; in-flight reads still complete.
- `req`  input  N_REQ  per-requester read request; held until granted.
- `req_adr`  input  N_REQ*ADR_W  per-requester address; requester i uses bits [i*ADR_W +: ADR_W]; must be stable while `req[i]` is high.
- `gnt`  output  N_REQ  one-hot grant; combinational in the request cycle.
- `rvalid`  output  N_REQ  one-hot; `rdata` belongs to requester i this cycle.
- `rdata`  output  1  returned sprite bit.
- `bram_sprite_adr`  output  ADR_W  registered BRAM address.
- `bram_sprite_data`  input  1  BRAM read data.

## Operation
- **Grant logic**
  - Each cycle with `fetch_en`=1 and any `req` high, exactly one `gnt` bit is set.
  - No `gnt` bit is ever set for a requester with `req`=0.
- **Round-robin selection**
  - Pointer `ptr` holds the index of the highest-priority requester.
  - Search order: ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1.
  - On a grant to requester k, `ptr` ← (k+1) mod N_REQ.
  - With no grant, `ptr` holds.
- **Address and tag capture**
  - On the edge ending a grant cycle, `bram_sprite_adr` ← `req_adr` of the granted requester.
  - A tag pipeline records {valid, index} for each grant; its depth is RD_LAT+1 registers.
  - With no grant, `bram_sprite_adr` holds its value and a valid=0 tag enters the pipe.
- **Return path**
  - `rvalid[i]` = tag pipe output valid AND index==i.
  - `rdata` = `bram_sprite_data`, passed through; its meaning is defined only when an `rvalid` bit is high.
- **Requester handshake**
  - A requester drops `req` or changes `req_adr` only in the cycle after seeing `gnt`.
  - Back-to-back requests from the same requester are legal; round-robin spaces them whenever others are waiting.
- **`fetch_en` behaviour**
  - `fetch_en`=0 blocks new grants and does not touch `ptr`.
  - Tags already in the pipe drain normally.
- **Reset**
  - Asynchronous assertion clears `ptr`=0, `bram_sprite_adr`=0 and all tags.
  - While `reset_n`=0: `gnt`=0 and `rvalid`=0.
  - Reads in flight when reset asserts are discarded; their `rvalid` never appears.

## Timing
- Grant cycle t: `gnt[k]`=1.
- Cycle t+1: `bram_sprite_adr` shows `req_adr[k]`.
- Cycle t+1+RD_LAT: `rvalid[k]`=1 and `rdata` is valid.
- Total grant-to-data latency is RD_LAT+1 cycles; with the default, 2.
- Throughput is one read per cycle, sustained indefinitely.
- Worst-case wait for a continuously requesting client is N_REQ-1 cycles, round-robin build only.
- Reset values: `gnt`=0, `rvalid`=0, `bram_sprite_adr`=0; internal `ptr`=0.
- First grant is possible in the first cycle after `reset_n` deasserts.

## Configuration
- `SPRITE_ARB_FIXED_PRIO_EN` defined:
  - Fixed priority; the lowest index among active requests always wins.
  - `ptr` logic is compiled out.
  - Starvation of higher indices is permitted.
- Macro undefined: round-robin as described under Operation. This is the default build.

## Structure
- Shared package `display_pkg` holds:
  - `SPRITE_ADR_W` = 16, the BRAM latency constant `SPRITE_RD_LAT` = 1, and `MAX_SPRITES` = 8.
  - A typedef for the {valid, index} tag.
- One sub-module, `rr_pick`: given the request vector and pointer, returns the one-hot grant and encoded index.
  - Purely combinational; reused by future shared-resource arbiters such as the font BRAM.

## Test plan
- **Single requester:** `req`=3'b001, `req_adr[0]`=16'h0123 in cycle 5 → `gnt`=001 in cycle 5; `bram_sprite_adr`=0x0123 in cycle 6; `rvalid`=001 in cycle 7 with `rdata` equal to the BRAM model bit.
- **All three requesting continuously from reset:** grants go 001, 010, 100, 001, …; each requester receives exactly one `rvalid` per 3 cycles, with `rdata` matching its own address.
- **Reads held off:** with `fetch_en`=0 for 4 cycles while `req`=111, `gnt` stays 000 and `ptr` is unchanged; after `fetch_en` rises, the grant order resumes where it stopped.
- **Reset mid-flight:** grant to requester 2, then pull `reset_n` low one cycle later → no `rvalid` for that read; `bram_sprite_adr`=0 immediately.
- **Fixed-priority build:** with `SPRITE_ARB_FIXED_PRIO_EN` and `req`=011 held for 5 cycles, `gnt`=001 every cycle and requester 1 is never granted.
- **`RD_LAT`=3:** grant in cycle 10 → `rvalid` in cycle 14, with no other `rvalid` bits set.

Source files
------------

// File: rtl/display_pkg.sv
// Shared display constants and the {valid, index} tag carried by sprite BRAM reads.
// Imported by sprite_rom_arbiter and rr_pick.
package display_pkg;

    localparam int SPRITE_ADR_W  = 16;
    localparam int SPRITE_RD_LAT = 1;
    localparam int MAX_SPRITES   = 8;
    localparam int SPRITE_IDX_W  = $clog2(MAX_SPRITES);

    typedef struct packed {
        logic                    valid;
        logic [SPRITE_IDX_W-1:0] idx;
    } sprite_tag_t;

    // Index following i in a ring of n requesters.
    function automatic logic [SPRITE_IDX_W-1:0] next_idx(input logic [SPRITE_IDX_W-1:0] i,
                                                         input int n);
        return (int'(i) == n - 1) ? '0 : i + 1'b1;
    endfunction

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; searches ptr, ptr+1, ... wrapping at N.
// A constant zero ptr turns it into a fixed lowest-index-first picker.
module rr_pick
    import display_pkg::*;
#(
    parameter int N     = 3,
    parameter int IDX_W = SPRITE_IDX_W
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    localparam logic [N-1:0] ONE = N'(1);

    logic [IDX_W-1:0] cand [N];
    logic [N-1:0]     hit;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            // ptr < N, so one conditional subtract is the whole modulo
            assign sum      = {1'b0, ptr} + (IDX_W+1)'(gi);
            assign cand[gi] = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N))
                                                     : sum[IDX_W-1:0];
            assign hit[gi]  = |(req & (ONE << cand[gi]));
            assign gnt[gi]  = found && (idx == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int o = 0; o < N; o++) begin
            if (!found && hit[o]) begin
                found = 1'b1;
                idx   = cand[o];
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one single-port 1-bit sprite BRAM among N_REQ renderers, returning tagged read bits.
// Define SPRITE_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module sprite_rom_arbiter
    import display_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int ADR_W  = SPRITE_ADR_W,
    parameter int RD_LAT = SPRITE_RD_LAT
) (
    input  logic                   clk_65mhz,
    input  logic                   reset_n,
    input  logic                   fetch_en,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*ADR_W-1:0] req_adr,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       rvalid,
    output logic                   rdata,
    output logic [ADR_W-1:0]       bram_sprite_adr,
    input  logic                   bram_sprite_data
);

    logic [N_REQ-1:0]        pick_gnt;
    logic [SPRITE_IDX_W-1:0] pick_idx;
    logic [SPRITE_IDX_W-1:0] pick_ptr;
    logic                    pick_found;
    logic                    grant_en;
    logic                    grant_any;
    logic [ADR_W-1:0]        adr_reg;
    logic [ADR_W-1:0]        adr_arr [MAX_SPRITES];
    sprite_tag_t             tag_reg [RD_LAT+1];
    sprite_tag_t             tag_out;

    // Gating with reset_n keeps gnt low for the whole time reset is held
    assign grant_en  = fetch_en & reset_n;
    assign grant_any = pick_found & grant_en;
    assign gnt       = pick_gnt & {N_REQ{grant_en}};

`ifdef SPRITE_ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [SPRITE_IDX_W-1:0] ptr_reg;

    always_ff @(posedge clk_65mhz or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg <= '0;
        end else if (grant_any) begin
            ptr_reg <= next_idx(pick_idx, N_REQ);
        end
    end

    assign pick_ptr = ptr_reg;
`endif

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (SPRITE_IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    genvar gi;
    generate
        // Padded to MAX_SPRITES so the encoded index selects without range gaps
        for (gi = 0; gi < MAX_SPRITES; gi++) begin : g_adr
            if (gi < N_REQ) begin : g_used
                assign adr_arr[gi] = req_adr[gi*ADR_W +: ADR_W];
            end else begin : g_pad
                assign adr_arr[gi] = '0;
            end
        end
        for (gi = 0; gi < N_REQ; gi++) begin : g_rvalid
            assign rvalid[gi] = tag_out.valid && (tag_out.idx == SPRITE_IDX_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk_65mhz or negedge reset_n) begin
        if (!reset_n) begin
            adr_reg <= '0;
        end else if (grant_any) begin
            adr_reg <= adr_arr[pick_idx];
        end
    end

    // Stage 0 lines up with the address register; the last stage with BRAM data
    always_ff @(posedge clk_65mhz or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s <= RD_LAT; s++) begin
                tag_reg[s] <= '0;
            end
        end else begin
            tag_reg[0] <= sprite_tag_t'{valid: grant_any, idx: pick_idx};
            for (int s = 1; s <= RD_LAT; s++) begin
                tag_reg[s] <= tag_reg[s-1];
            end
        end
    end

    assign tag_out         = tag_reg[RD_LAT];
    assign bram_sprite_adr = adr_reg;
    assign rdata           = bram_sprite_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: directed vector table, reset corner cases and random
// traffic checked against a queue-based model, on RD_LAT=1 and RD_LAT=3 instances.
module tb_sprite_rom_arbiter;

    localparam int N  = 3;
    localparam int AW = 16;

    typedef struct {
        int          due;
        int          idx;
        logic [15:0] adr;
    } pend_t;

    typedef struct {
        logic        fe;
        logic [2:0]  rq;
        logic [15:0] a0, a1, a2;
        logic [2:0]  g_rr;
        logic [2:0]  g_fp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        fetch_en;
    logic [2:0]  req;
    logic [47:0] req_adr;
    logic [2:0]  gnt1, gnt3, rv1, rv3;
    logic        rd1, rd3;
    logic [15:0] badr1, badr3;
    logic        bd1, bd3;
    logic [15:0] h3_0, h3_1;

    always #5 clk = ~clk;

    sprite_rom_arbiter #(.N_REQ(N), .ADR_W(AW), .RD_LAT(1)) dut1 (
        .clk_65mhz        (clk),
        .reset_n          (reset_n),
        .fetch_en         (fetch_en),
        .req              (req),
        .req_adr          (req_adr),
        .gnt              (gnt1),
        .rvalid           (rv1),
        .rdata            (rd1),
        .bram_sprite_adr  (badr1),
        .bram_sprite_data (bd1)
    );

    sprite_rom_arbiter #(.N_REQ(N), .ADR_W(AW), .RD_LAT(3)) dut3 (
        .clk_65mhz        (clk),
        .reset_n          (reset_n),
        .fetch_en         (fetch_en),
        .req              (req),
        .req_adr          (req_adr),
        .gnt              (gnt3),
        .rvalid           (rv3),
        .rdata            (rd3),
        .bram_sprite_adr  (badr3),
        .bram_sprite_data (bd3)
    );

    function automatic logic fbit(input logic [15:0] a);
        return ^(a & 16'hA5C3) ^ a[15];
    endfunction

    // BRAM models: data = f(address registered RD_LAT cycles earlier)
    always @(posedge clk) begin
        bd1  <= fbit(badr1);
        h3_0 <= badr3;
        h3_1 <= h3_0;
        bd3  <= fbit(h3_1);
    end

    int    n_chk = 0;
    int    n_fail = 0;
    int    mptr;
    int    mcyc;
    logic [15:0] m_adr;
    pend_t q1[$];
    pend_t q3[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at model cycle %0d: got %0h expected %0h", name, mcyc, act, exp);
        end
    endtask

    task automatic model_reset();
        mptr  = 0;
        mcyc  = 0;
        m_adr = '0;
        q1.delete();
        q3.delete();
    endtask

    function automatic logic [2:0] model_pick(input logic fe, input logic [2:0] rq, input int p);
        int start = p;
`ifdef SPRITE_ARB_FIXED_PRIO_EN
        start = 0;
`endif
        if (!fe) return 3'b000;
        for (int o = 0; o < N; o++) begin
            int k = (start + o) % N;
            if (rq[k]) return 3'b001 << k;
        end
        return 3'b000;
    endfunction

    task automatic check_cycle(output logic [2:0] eg);
        logic [2:0] er;
        pend_t      p;
        int         k;
        eg = model_pick(fetch_en, req, mptr);
        chk("gnt", gnt1, eg);
        chk("gnt_lat3", gnt3, eg);
        chk("bram_adr", badr1, m_adr);
        chk("bram_adr_lat3", badr3, m_adr);
        er = 3'b000;
        if (q1.size() > 0 && q1[0].due == mcyc) begin
            p  = q1.pop_front();
            er = 3'b001 << p.idx;
            chk("rdata", rd1, fbit(p.adr));
        end
        chk("rvalid", rv1, er);
        er = 3'b000;
        if (q3.size() > 0 && q3[0].due == mcyc) begin
            p  = q3.pop_front();
            er = 3'b001 << p.idx;
            chk("rdata_lat3", rd3, fbit(p.adr));
        end
        chk("rvalid_lat3", rv3, er);
        $display("cyc %0d fe=%b req=%b gnt=%b rvalid=%b/%b adr=%h", mcyc, fetch_en, req,
                 gnt1, rv1, rv3, badr1);
        if (eg != 3'b000) begin
            k = 0;
            for (int i = 0; i < N; i++) if (eg[i]) k = i;
            m_adr = req_adr[k*AW +: AW];
            q1.push_back('{mcyc + 2, k, m_adr});
            q3.push_back('{mcyc + 4, k, m_adr});
            mptr = (k + 1) % N;
        end
        mcyc++;
    endtask

    task automatic step(input logic fe, input logic [2:0] rq, input logic [15:0] a0,
                        input logic [15:0] a1, input logic [15:0] a2, output logic [2:0] eg);
        @(posedge clk);
        #1;
        fetch_en = fe;
        req      = rq;
        req_adr  = {a2, a1, a0};
        @(negedge clk);
        check_cycle(eg);
    endtask

    vec_t        vt[$];
    logic [2:0]  g;
    logic [2:0]  prev_g;
    logic [2:0]  rq;
    logic [15:0] ra [3];
    logic        fe;
    int          wcnt [3];

    task automatic add(input logic f, input logic [2:0] r, input logic [15:0] a0,
                       input logic [15:0] a1, input logic [15:0] a2,
                       input logic [2:0] grr, input logic [2:0] gfp);
        vt.push_back('{f, r, a0, a1, a2, grr, gfp});
    endtask

    initial begin
        // Directed table, starting from reset with ptr = 0
        add(1, 3'b111, 16'h1357, 16'h2468, 16'h9ABC, 3'b001, 3'b001);
        add(1, 3'b111, 16'h1357, 16'h2468, 16'h9ABC, 3'b010, 3'b001);
        add(1, 3'b111, 16'h1357, 16'h2468, 16'h9ABC, 3'b100, 3'b001);
        add(1, 3'b111, 16'h1357, 16'h2468, 16'h9ABC, 3'b001, 3'b001);
        add(1, 3'b111, 16'h1357, 16'h2468, 16'h9ABC, 3'b010, 3'b001);
        for (int i = 0; i < 4; i++)
            add(0, 3'b111, 16'h1357, 16'h2468, 16'h9ABC, 3'b000, 3'b000);
        add(1, 3'b111, 16'h1357, 16'h2468, 16'h9ABC, 3'b100, 3'b001);
        add(1, 3'b011, 16'h1357, 16'h2468, 16'h0000, 3'b001, 3'b001);
        add(1, 3'b011, 16'h1357, 16'h2468, 16'h0000, 3'b010, 3'b001);
        add(1, 3'b011, 16'h1357, 16'h2468, 16'h0000, 3'b001, 3'b001);
        add(1, 3'b011, 16'h1357, 16'h2468, 16'h0000, 3'b010, 3'b001);
        add(1, 3'b011, 16'h1357, 16'h2468, 16'h0000, 3'b001, 3'b001);
        add(1, 3'b010, 16'h0000, 16'h2468, 16'h0000, 3'b010, 3'b010);
        add(1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 3'b000);
        add(1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 3'b000);
        add(1, 3'b001, 16'h0123, 16'h0000, 16'h0000, 3'b001, 3'b001);
        for (int i = 0; i < 4; i++)
            add(1, 3'b000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 3'b000);

        // Reset state, with requests pending to show they are ignored
        reset_n  = 1'b0;
        fetch_en = 1'b1;
        req      = 3'b111;
        req_adr  = {16'h9ABC, 16'h2468, 16'h1357};
        mcyc     = 0;
        #12;
        chk("rst_gnt", gnt1, 3'b000);
        chk("rst_rvalid", rv1, 3'b000);
        chk("rst_adr", badr1, 16'h0000);
        chk("rst_rvalid_lat3", rv3, 3'b000);
        @(posedge clk);
        #1;
        chk("rst_gnt_after_edge", gnt3, 3'b000);
        chk("rst_adr_after_edge", badr3, 16'h0000);
        req = 3'b000;
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].fe, vt[i].rq, vt[i].a0, vt[i].a1, vt[i].a2, g);
`ifdef SPRITE_ARB_FIXED_PRIO_EN
            chk("table_gnt", gnt1, vt[i].g_fp);
`else
            chk("table_gnt", gnt1, vt[i].g_rr);
`endif
        end

        // Reset one cycle after a grant: in-flight read must vanish
        step(1, 3'b100, 16'h0000, 16'h0000, 16'hBEEF, g);
        @(posedge clk);
        #1;
        req = 3'b000;
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_adr", badr1, 16'h0000);
        chk("midrst_adr_lat3", badr3, 16'h0000);
        req = 3'b111;
        #1;
        chk("midrst_gnt", gnt1, 3'b000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_rvalid", rv1, 3'b000);
            chk("midrst_rvalid_lat3", rv3, 3'b000);
        end
        req = 3'b000;
        #1;
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) step(1, 3'b000, 16'h0, 16'h0, 16'h0, g);

        // Random traffic obeying the hold-until-granted handshake
        rq     = 3'b000;
        prev_g = 3'b000;
        for (int i = 0; i < N; i++) begin
            ra[i]   = '0;
            wcnt[i] = 0;
        end
        for (int n = 0; n < 320; n++) begin
            for (int i = 0; i < N; i++) begin
                if (n >= 300) begin
                    if (prev_g[i]) rq[i] = 1'b0;
                end else if (prev_g[i]) begin
                    rq[i] = ($urandom_range(0, 3) != 0);
                    ra[i] = 16'($urandom);
                end else if (!rq[i]) begin
                    rq[i] = ($urandom_range(0, 2) == 0);
                    if (rq[i]) ra[i] = 16'($urandom);
                end
            end
            fe = ($urandom_range(0, 9) != 0);
            step(fe, rq, ra[0], ra[1], ra[2], prev_g);
`ifndef SPRITE_ARB_FIXED_PRIO_EN
            for (int i = 0; i < N; i++) begin
                if (prev_g[i]) wcnt[i] = 0;
                else if (rq[i] && fe) wcnt[i]++;
                if (rq[i]) chk("rr_wait_bound", 32'(wcnt[i] > N - 1), 32'd0);
            end
`endif
        end
        for (int i = 0; i < 4; i++) step(1, 3'b000, 16'h0, 16'h0, 16'h0, g);
        chk("drained", 32'(q1.size() + q3.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
